// File: rtl/prm_scan_pkg.sv
// ---------------------------------------------------------------------------
// prm_scan_pkg
// Shared definitions for the PRM obstacle scan sequencer.
//   OBS_CODE_W   : width of one obstacle voxel code (checker inputs O..A).
//   scan_state_e : sequencer states.
//                  IDLE  - waiting for start
//                  SCAN  - accepting codes
//                  DRAIN - folding in the last checker result
//                  DONE  - presenting the result
// ---------------------------------------------------------------------------
package prm_scan_pkg;

  localparam int OBS_CODE_W = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/prm_obs_scan_seq.sv
// ---------------------------------------------------------------------------
// prm_obs_scan_seq
// Drives a bank of PRM edge obstacle checkers with a stream of obstacle voxel
// codes. It accumulates the bank's per-edge hit bits into a sticky "blocked"
// bitmap and counts the codes it has checked. At the end of the stream it
// hands the bitmap and the count to the roadmap builder.
//
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   start        : begin a scan (only honoured in IDLE)
//   obs_valid    : obstacle stream valid
//   obs_code     : obstacle code
//   obs_last     : final code of the stream
//   obs_ready    : sequencer accepts an obstacle code
//   chk_code     : registered code broadcast to every checker
//   chk_mask     : combinational edge_mask bits returned by the bank
//   res_valid    : result handshake valid
//   res_ready    : result handshake ready
//   res_blocked  : bit i set when any scanned obstacle blocks edge i
//   res_count    : number of codes checked (saturating)
//   busy         : sequencer is not in IDLE
// ---------------------------------------------------------------------------
module prm_obs_scan_seq
  import prm_scan_pkg::*;
#(
  parameter int NUM_EDGES = 8,
  parameter int CNT_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  obs_valid,
  input  logic [OBS_CODE_W-1:0] obs_code,
  input  logic                  obs_last,
  output logic                  obs_ready,
  output logic [OBS_CODE_W-1:0] chk_code,
  input  logic [NUM_EDGES-1:0]  chk_mask,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [NUM_EDGES-1:0]  res_blocked,
  output logic [CNT_W-1:0]      res_count,
  output logic                  busy
);

  scan_state_e           state_q,    state_d;
  logic [OBS_CODE_W-1:0] chk_code_q, chk_code_d;
  logic                  chk_vld_q,  chk_vld_d;
  logic [NUM_EDGES-1:0]  blocked_q,  blocked_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic                  accept;

  // Handshake on the obstacle stream: codes are only taken while scanning.
  assign accept = (state_q == SCAN) && obs_valid;

  // Next-state and accumulator logic.
  always_comb begin
    state_d    = state_q;
    chk_code_d = chk_code_q;
    chk_vld_d  = 1'b0;
    blocked_d  = blocked_q;
    count_d    = count_q;

    // The bank answers combinationally from chk_code, so the mask belongs to
    // the code registered last cycle; fold it only when that code is fresh.
    if (chk_vld_q) begin
      blocked_d = blocked_q | chk_mask;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          blocked_d = '0;
          count_d   = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (accept) begin
          chk_code_d = obs_code;
          chk_vld_d  = 1'b1;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
          if (obs_last) begin
            state_d = DRAIN;
          end
        end
      end
      // One cycle for the mask of the final code to be folded in.
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      chk_code_q <= '0;
      chk_vld_q  <= 1'b0;
      blocked_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      chk_code_q <= chk_code_d;
      chk_vld_q  <= chk_vld_d;
      blocked_q  <= blocked_d;
      count_q    <= count_d;
    end
  end

  assign obs_ready   = (state_q == SCAN);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign chk_code    = chk_code_q;
  assign res_blocked = blocked_q;
  assign res_count   = count_q;

endmodule
